// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW core's memory-side blocks.
package vliw_pkg;

  // Bus arbiter access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } arb_state_e;

  // Requester slot reserved for instruction fetch; FU n sits at slot 1+n.
  localparam int FETCH_REQ = 0;

  // Width of the external data bus and of every load/store data word.
  localparam int BUS_DATA_W = 64;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: returns the first asserted request at or
// above ptr_i, wrapping around, as both a one-hot vector and an index.
module rr_priority_select #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] pos;
  logic          found;

  // Walk the requests starting at the pointer and keep the first hit.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int off = 0; off < N; off++) begin
      pos = IW'((int'(ptr_i) + off) % N);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between instruction fetch (slot 0) and the
// functional-unit load/store ports, one fixed-latency transaction at a time.
module mem_bus_arbiter
  import vliw_pkg::*;
#(
  parameter int NFU                   = 2,
  parameter int PHYSICAL_ADDRESS_SIZE = 56,
  parameter int BUS_LATENCY           = 2,
  localparam int NREQ                 = NFU + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req,
  input  logic [PHYSICAL_ADDRESS_SIZE-1:0] reqAddr [NREQ],
  input  logic [NREQ-1:0]                  reqWrite,
  input  logic [BUS_DATA_W-1:0]            reqData [NREQ],
  output logic [NREQ-1:0]                  grant,
  output logic [NREQ-1:0]                  done,
  output logic [NREQ-1:0]                  error,
  output logic [BUS_DATA_W-1:0]            rdata [NREQ],
  output logic [PHYSICAL_ADDRESS_SIZE-1:0] addressBus,
  output logic [BUS_DATA_W-1:0]            dataOut,
  input  logic [BUS_DATA_W-1:0]            dataIn,
  output logic                             enableWrite,
  output logic                             busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int PTR_W = (NFU > 1) ? $clog2(NFU) : 1;
  localparam int CNT_W = 4;

  arb_state_e                       state_q, state_d;
  logic [IDX_W-1:0]                 win_q, win_d;
  logic                             write_q, write_d;
  logic                             err_q, err_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                             fetch_last_q, fetch_last_d;
  logic [NREQ-1:0]                  grant_q, grant_d;
  logic [NREQ-1:0]                  done_q, done_d;
  logic [NREQ-1:0]                  error_q, error_d;
  logic [PHYSICAL_ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [BUS_DATA_W-1:0]            wdata_q, wdata_d;
  logic                             we_q, we_d;
  logic [BUS_DATA_W-1:0]            rdata_q [NREQ];
  logic [BUS_DATA_W-1:0]            rdata_d [NREQ];

  logic [NFU-1:0]   fu_gnt;
  logic [PTR_W-1:0] fu_idx;
  logic             fu_any;
  logic             fetch_wins;
  logic [IDX_W-1:0] win;

  rr_priority_select #(
    .N  (NFU),
    .IW (PTR_W)
  ) u_fu_select (
    .req_i (req[NREQ-1:1]),
    .ptr_i (rr_ptr_q),
    .gnt_o (fu_gnt),
    .idx_o (fu_idx)
  );

  assign fu_any = |fu_gnt;

  // Fetch normally wins, but never twice in a row while an FU is waiting,
  // so each FU loses at most one fetch transaction per arbitration round.
  assign fetch_wins = req[FETCH_REQ] && !(fetch_last_q && fu_any);
  assign win        = fetch_wins ? IDX_W'(FETCH_REQ) : IDX_W'(fu_idx) + IDX_W'(1);

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    write_d      = write_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    fetch_last_d = fetch_last_q;
    grant_d      = '0;
    done_d       = '0;
    error_d      = '0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          win_d          = win;
          write_d        = reqWrite[win];
          grant_d[win]   = 1'b1;
          fetch_last_d   = (win == IDX_W'(FETCH_REQ));
          if (reqAddr[win][2:0] != 3'b000) begin
            // Misaligned: report it without ever touching the bus.
            err_d   = 1'b1;
            state_d = ST_COMPLETE;
          end else begin
            err_d   = 1'b0;
            addr_d  = reqAddr[win];
            wdata_d = reqData[win];
            we_d    = reqWrite[win];
            cnt_d   = CNT_W'(BUS_LATENCY - 1);
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (!write_q) begin
            rdata_d[win_q] = dataIn;
          end
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          state_d = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        done_d[win_q]  = 1'b1;
        error_d[win_q] = err_q;
        if (win_q != IDX_W'(FETCH_REQ)) begin
          // Next FU search starts just past the FU that was served.
          rr_ptr_d = PTR_W'(int'(win_q) % NFU);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= ST_IDLE;
      win_q        <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      fetch_last_q <= 1'b0;
      grant_q      <= '0;
      done_q       <= '0;
      error_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      // NOTE: the load-data array is only NREQ words and is architecturally
      // visible as zero after reset, so it is cleared like any other register.
      for (int i = 0; i < NREQ; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      write_q      <= write_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      fetch_last_q <= fetch_last_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      error_q      <= error_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rdata_q      <= rdata_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign error       = error_q;
  assign rdata       = rdata_q;
  assign addressBus  = addr_q;
  assign dataOut     = wdata_q;
  assign enableWrite = we_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
